// File: rtl/debounce_pkg.sv
// Shared types for the switch debouncer: per-channel FSM states and synchronizer depth.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      WAIT_HI   = 2'b01,
      STABLE_HI = 2'b10,
      WAIT_LO   = 2'b11
   } deb_state_t;

   localparam int SYNC_STAGES = 2;

   // Clean output level implied by an FSM state.
   function automatic logic level_of(input deb_state_t st);
      return (st == STABLE_HI) || (st == WAIT_LO);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: two-flop synchronizer feeding a stability FSM with counter.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = 1000,
   parameter int CNT_W         = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic chg_o
);

   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s2_s;
   deb_state_t             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q;
   logic                   chg_q, chg_d;

   // Synchronizer shift chain for the asynchronous raw input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      end
   end

   assign s2_s = sync_q[SYNC_STAGES-1];

   // Next state; the abort test is checked before the count-complete test.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      chg_d   = 1'b0;
      case (state_q)
         STABLE_LO: begin
            if (s2_s) begin
               state_d = WAIT_HI;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         WAIT_HI: begin
            if (!s2_s) begin
               state_d = STABLE_LO;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_DONE) begin
               state_d = STABLE_HI;
               cnt_d   = CNT_ZERO;
               chg_d   = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!s2_s) begin
               state_d = WAIT_LO;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         WAIT_LO: begin
            if (s2_s) begin
               state_d = STABLE_HI;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_DONE) begin
               state_d = STABLE_LO;
               cnt_d   = CNT_ZERO;
               chg_d   = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // FSM state, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STABLE_LO;
         cnt_q   <= CNT_ZERO;
         level_q <= 1'b0;
         chg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_of(state_d);
         chg_q   <= chg_d;
      end
   end

   assign level_o = level_q;
   assign chg_o   = chg_q;

endmodule

// File: rtl/or_input_debounce.sv
// Two independent debounce channels producing clean a/b levels and change pulses
// for the downstream two-input OR combiner.
module or_input_debounce #(
   parameter int STABLE_CYCLES = 1000,
   parameter int CNT_W         = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a_raw,
   input  logic b_raw,
   output logic a,
   output logic b,
   output logic a_chg,
   output logic b_chg
);

   debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_chan_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (a_raw),
      .level_o (a),
      .chg_o   (a_chg)
   );

   debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_chan_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (b_raw),
      .level_o (b),
      .chg_o   (b_chg)
   );

endmodule
